// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared definitions for the two-requester RAM port arbiter.
//   - DEF_DATA_W / DEF_ADDR_W : default RAM word and address widths (8x4 RAM)
//   - GNT_NONE / GNT0 / GNT1  : one-hot grant encoding used between the
//                               round-robin arbiter and the port sequencer
package ram_arb_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 3;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT0     = 2'b01;
  localparam logic [1:0] GNT1     = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Purely combinational two-way round-robin arbiter.
//   Ports:
//     eligible   in  [1:0]  requester n may be granted this cycle
//     last_grant in  1      index of the requester granted most recently
//     gnt        out [1:0]  one-hot grant (GNT_NONE when nobody is eligible)
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // On a tie the requester that was not served last wins; last_grant=1
  // therefore hands the tie to requester 0.
  always_comb begin
    gnt = GNT_NONE;
    case (eligible)
      2'b01:   gnt = GNT0;
      2'b10:   gnt = GNT1;
      2'b11:   gnt = last_grant ? GNT0 : GNT1;
      default: gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Round-robin arbiter and sequencer sharing one single-port RAM
//   (synchronous write, asynchronous read) between two requesters.
//   Ports:
//     clk, rst                      clock (rising edge), async active-high reset
//     req0/we0/addr0/wdata0         requester 0 transaction (held until ack)
//     ack0/rdata0                   requester 0 one-cycle completion + read data
//     req1/we1/addr1/wdata1         requester 1 transaction
//     ack1/rdata1                   requester 1 completion + read data
//     ram_we/ram_addr/ram_din       RAM port drive (zero when idle or in reset)
//     ram_dout                      RAM asynchronous read data
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  logic [1:0]        eligible;
  logic [1:0]        gnt;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  // A requester sitting in its ack cycle is not eligible, so its fields
  // (possibly a brand-new transaction) are never sampled in that cycle.
  assign eligible = {req1 & ~ack_q[1], req0 & ~ack_q[0]};

  rr_arbiter2 u_arb (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // RAM mux and next-state. The RAM port is forced idle while rst is high
  // because the ack flops clear asynchronously and would otherwise let a
  // held request drive the RAM during reset.
  always_comb begin
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_din      = '0;
    last_grant_d = last_grant_q;
    ack_d        = gnt;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    if (!rst) begin
      case (gnt)
        GNT0: begin
          ram_we   = we0;
          ram_addr = addr0;
          ram_din  = wdata0;
        end
        GNT1: begin
          ram_we   = we1;
          ram_addr = addr1;
          ram_din  = wdata1;
        end
        default: begin
          ram_we   = 1'b0;
          ram_addr = '0;
          ram_din  = '0;
        end
      endcase
    end

    if (gnt == GNT0) begin
      last_grant_d = 1'b0;
    end else if (gnt == GNT1) begin
      last_grant_d = 1'b1;
    end

    // Reads capture the asynchronous RAM output of the grant cycle;
    // writes leave the requester's rdata untouched.
    if (gnt[0] && !we0) begin
      rdata0_d = ram_dout;
    end
    if (gnt[1] && !we1) begin
      rdata1_d = ram_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      ack_q        <= 2'b00;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign ack0   = ack_q[0];
  assign ack1   = ack_q[1];
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Directed and randomized bench for ram_port_arbiter with a behavioural
//   8x4 RAM attached and a transaction-level reference model.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req_v = 2'b00;
  logic [1:0] we_v  = 2'b00;
  logic [2:0] addr_v  [2] = '{3'd0, 3'd0};
  logic [3:0] wdata_v [2] = '{4'd0, 4'd0};

  logic       ack0, ack1;
  logic [3:0] rdata0, rdata1;
  logic       ram_we;
  logic [2:0] ram_addr;
  logic [3:0] ram_din;
  logic [3:0] ram_dout;

  // Behavioural RAM: synchronous write, asynchronous read
  logic [3:0] tb_mem [8] = '{4'h1, 4'h4, 4'h7, 4'h2, 4'hD, 4'h0, 4'h3, 4'h6};

  // Reference model state: what each requester should currently see
  logic [3:0] mem_m  [8] = '{4'h1, 4'h4, 4'h7, 4'h2, 4'hD, 4'h0, 4'h3, 4'h6};
  logic [1:0] ack_m = 2'b00;
  logic [3:0] rdata_m [2] = '{4'h0, 4'h0};
  int         last_m = 1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) tb_mem[ram_addr] <= ram_din;
  end
  assign ram_dout = tb_mem[ram_addr];

  ram_port_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req_v[0]),
    .we0      (we_v[0]),
    .addr0    (addr_v[0]),
    .wdata0   (wdata_v[0]),
    .ack0     (ack0),
    .rdata0   (rdata0),
    .req1     (req_v[1]),
    .we1      (we_v[1]),
    .addr1    (addr_v[1]),
    .wdata1   (wdata_v[1]),
    .ack1     (ack1),
    .rdata1   (rdata1),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // One comparison: counts it and reports any difference
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents (or withdraws) a transaction on one requester
  task automatic applyStimulus(input int n, input logic r, input logic w,
                               input logic [2:0] a, input logic [3:0] d);
    req_v[n]   = r;
    we_v[n]    = w;
    addr_v[n]  = a;
    wdata_v[n] = d;
  endtask

  // Who the rules say is served this cycle (-1 = nobody)
  function automatic int pick();
    bit e0, e1;
    e0 = req_v[0] && !ack_m[0];
    e1 = req_v[1] && !ack_m[1];
    if (e0 && e1) return (last_m == 1) ? 0 : 1;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  // Compares every output with the model for the current cycle
  task automatic checkOutput(output int w);
    logic       exp_we;
    logic [2:0] exp_addr;
    logic [3:0] exp_din;
    w        = pick();
    exp_we   = (w >= 0) ? we_v[w]    : 1'b0;
    exp_addr = (w >= 0) ? addr_v[w]  : 3'd0;
    exp_din  = (w >= 0) ? wdata_v[w] : 4'd0;
    chk("ack0",     8'(ack0),     8'(ack_m[0]));
    chk("ack1",     8'(ack1),     8'(ack_m[1]));
    chk("rdata0",   8'(rdata0),   8'(rdata_m[0]));
    chk("rdata1",   8'(rdata1),   8'(rdata_m[1]));
    chk("ram_we",   8'(ram_we),   8'(exp_we));
    chk("ram_addr", 8'(ram_addr), 8'(exp_addr));
    chk("ram_din",  8'(ram_din),  8'(exp_din));
  endtask

  // Applies the effect of the clock edge that ends the cycle to the model
  task automatic modelEdge(input int w);
    ack_m = 2'b00;
    if (w >= 0) begin
      ack_m[w] = 1'b1;
      last_m   = w;
      if (we_v[w]) mem_m[addr_v[w]] = wdata_v[w];
      else         rdata_m[w] = mem_m[addr_v[w]];
    end
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1
  task automatic run_cycle();
    int w;
    #2;
    checkOutput(w);
    modelEdge(w);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse in the middle of a cycle
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_ack0",   8'(ack0),     8'h0);
    chk("rst_ack1",   8'(ack1),     8'h0);
    chk("rst_rdata0", 8'(rdata0),   8'h0);
    chk("rst_rdata1", 8'(rdata1),   8'h0);
    chk("rst_ram_we", 8'(ram_we),   8'h0);
    chk("rst_addr",   8'(ram_addr), 8'h0);
    chk("rst_din",    8'(ram_din),  8'h0);
    ack_m   = 2'b00;
    rdata_m = '{4'h0, 4'h0};
    last_m  = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("init_ack0", 8'(ack0), 8'h0);
    chk("init_rdata1", 8'(rdata1), 8'h0);

    // Single write then read on requester 0
    applyStimulus(0, 1'b1, 1'b1, 3'd3, 4'hA);
    #1 chk("wr_ram_we", 8'(ram_we), 8'h1);
    run_cycle();
    applyStimulus(0, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("wr_ack0", 8'(ack0), 8'h1);
    #1 chk("wr_ack_cycle_we", 8'(ram_we), 8'h0);
    run_cycle();
    applyStimulus(0, 1'b1, 1'b0, 3'd3, 4'h0);
    run_cycle();
    applyStimulus(0, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("rd_ack0", 8'(ack0), 8'h1);
    chk("rd_data0", 8'(rdata0), 8'hA);
    run_cycle();

    // Simultaneous first requests after reset, same address
    do_reset();
    applyStimulus(0, 1'b1, 1'b0, 3'd1, 4'h0);
    applyStimulus(1, 1'b1, 1'b1, 3'd1, 4'h5);
    #1 chk("sim_first_we", 8'(ram_we), 8'h0);
    run_cycle();
    applyStimulus(0, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("sim_rdata0_old", 8'(rdata0), 8'h4);
    #1 chk("sim_second_we", 8'(ram_we), 8'h1);
    run_cycle();
    applyStimulus(1, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("sim_ack1", 8'(ack1), 8'h1);
    applyStimulus(0, 1'b1, 1'b0, 3'd1, 4'h0);
    run_cycle();
    applyStimulus(0, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("sim_readback", 8'(rdata0), 8'h5);
    run_cycle();

    // Continuous contention: requester 0 uses even, requester 1 odd addresses
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 2; n++) begin
        if (!req_v[n] || ack_m[n])
          applyStimulus(n, 1'b1, 1'b0, 3'((2 * (k % 4)) + n), 4'h0);
      end
      #1 chk("contend_owner", 8'(ram_addr[0]), 8'((k + 1) % 2));
      run_cycle();
    end
    applyStimulus(0, 1'b0, 1'b0, 3'd0, 4'h0);
    applyStimulus(1, 1'b0, 1'b0, 3'd0, 4'h0);
    run_cycle();

    // Single-requester throughput
    for (int k = 0; k < 6; k++) begin
      if (!req_v[1] || ack_m[1]) applyStimulus(1, 1'b1, 1'b0, 3'(k), 4'h0);
      chk("thru_ack1", 8'(ack1), 8'(k % 2));
      run_cycle();
    end
    applyStimulus(1, 1'b0, 1'b0, 3'd0, 4'h0);
    run_cycle();

    // Reset while ack1 is high, then a tie must go to requester 0
    applyStimulus(1, 1'b1, 1'b1, 3'd6, 4'hC);
    run_cycle();
    applyStimulus(1, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("pre_rst_ack1", 8'(ack1), 8'h1);
    do_reset();
    applyStimulus(0, 1'b1, 1'b0, 3'd6, 4'h0);
    applyStimulus(1, 1'b1, 1'b0, 3'd2, 4'h0);
    #1 chk("tie_after_rst", 8'(ram_addr), 8'h6);
    run_cycle();
    applyStimulus(0, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("committed_write", 8'(rdata0), 8'hC);
    run_cycle();

    // Randomized traffic against the model, with a reset in the middle
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      for (int n = 0; n < 2; n++) begin
        if (!(req_v[n] && !ack_m[n])) begin
          if ($urandom_range(0, 3) != 0)
            applyStimulus(n, 1'b1, 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
          else
            applyStimulus(n, 1'b0, 1'b0, 3'd0, 4'h0);
        end
      end
      run_cycle();
    end

    applyStimulus(0, 1'b0, 1'b0, 3'd0, 4'h0);
    applyStimulus(1, 1'b0, 1'b0, 3'd0, 4'h0);
    run_cycle();
    run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the team's single-port 8x4 RAM. The RAM has a synchronous write and an asynchronous read.
- Each requester issues one read or write per transaction using a req/ack handshake. The block multiplexes the winner onto the RAM port, captures read data, and returns a one-cycle ack.
- It sits between two client engines and the RAM instance.

Parameters:
- DATA_W, 4, RAM word width.
- ADDR_W, 3, RAM address width (depth = 2**ADDR_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 transaction request.
- we0  input  1  requester 0: 1 = write, 0 = read.
- addr0  input  ADDR_W  requester 0 address.
- wdata0  input  DATA_W  requester 0 write data.
- ack0  output  1  requester 0 transaction complete, one-cycle pulse.
- rdata0  output  DATA_W  requester 0 read data, valid while ack0=1.
- req1, we1, addr1, wdata1, ack1, rdata1: same as above, for requester 1.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_din  output  DATA_W  RAM write data.
- ram_dout  input  DATA_W  RAM read data (asynchronous).

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst); it is fixed as such.
- Reset values: ack0=ack1=0, rdata0=rdata1=0, last_grant=1 (so requester 0 wins the first tie). While rst=1, ram_we=0, ram_addr=0, ram_din=0.
- Eligibility: requester n is eligible when req_n=1 and ack_n=0. A requester is never granted in the cycle its ack is high, so each requester completes at most one transaction every 2 cycles.
- Grant (combinational, same cycle):
  - only one eligible -> it wins;
  - both eligible -> the one not equal to last_grant wins;
  - none eligible -> no grant.
- RAM drive, grant cycle: ram_addr=addr_g, ram_din=wdata_g, ram_we=we_g.
- RAM drive, no grant: ram_we=0, ram_addr=0, ram_din=0.
- At the rising edge ending the grant cycle:
  - last_grant <= g;
  - ack_g <= 1 for exactly one cycle;
  - if we_g=0: rdata_g <= ram_dout (the pre-edge value at addr_g);
  - if we_g=1: rdata_g holds its previous value; the RAM write commits on the same edge.
- Latency: 1 cycle from grant to ack. A transaction that loses arbitration waits until it wins; round-robin bounds the wait to 1 transaction.
- Requester contract:
  - hold req/we/addr/wdata stable from assertion until the ack cycle;
  - in the ack cycle, req may stay high to present a new transaction with new fields;
  - deasserting req before ack is illegal; behaviour is undefined and not checked.
- rdata_n holds its last value outside ack cycles.
- Same-address hazard: a write granted in cycle t is visible to a read granted in cycle t+1 or later. No bypass is needed because the two grants never share a cycle.
- Reset mid-transaction: any pending or acked transaction is discarded and outputs return to reset values immediately. A write whose grant edge has already occurred is committed; otherwise it is not performed.
- Back-to-back with both requesters continuously requesting: grants alternate 0,1,0,1…, giving one RAM access per cycle.

Decomposition:
- Package ram_arb_pkg:
  - DATA_W and ADDR_W defaults;
  - grant encoding localparams GNT_NONE=2'b00, GNT0=2'b01, GNT1=2'b10.
- Sub-module rr_arbiter2, purely combinational:
  - inputs: eligible[1:0], last_grant;
  - outputs: one-hot gnt[1:0].
- The top module holds the last_grant register, the ack/rdata registers and the RAM mux.

Test Plan:
- Reset: assert rst mid-simulation with req0=1 -> ack0=ack1=0, rdata0=rdata1=0, ram_we=0 immediately, asynchronous to clk.
- Single write then read: req0 writes addr=3, wdata=4'hA; ack0 pulses 1 cycle later. Then req0 reads addr=3 -> ack0 with rdata0=4'hA. ram_we=1 only in the write grant cycle.
- Simultaneous first requests after reset: req0 reads addr=1, req1 writes addr=1, data 4'h5. Requester 0 is granted first; rdata0 = prior content of addr 1, not 4'h5. ack1 follows one cycle later, and a subsequent read of addr 1 returns 4'h5.
- Continuous contention: both requesters hold req high for 8 cycles -> grant order 0,1,0,1…; each ack pulses every other cycle; no cycle with ram_we from both requesters.
- Single-requester throughput: only req1 held high -> ack1 pattern 1,0,1,0; no grant is issued in ack cycles.
- Reset during an ack cycle: rst asserted while ack1=1 -> ack1 drops immediately. After release, last_grant=1, so the next tie goes to requester 0.
